// File: rtl/matmul_compute_if.sv
// ---------------------------------------------------------------------------
// matmul_compute_if
// AXI-Stream style link carrying the elements of C out of matmul_compute.
//   AXIS_TDATA   signed C element (OUTW bits), driven by the master
//   AXIS_TVALID  element valid, driven by the master
//   AXIS_TREADY  downstream ready, driven by the slave
// ---------------------------------------------------------------------------
interface matmul_compute_if #(
  parameter int OUTW = 28
) ();

  logic signed [OUTW-1:0] AXIS_TDATA;
  logic                   AXIS_TVALID;
  logic                   AXIS_TREADY;

  modport master (
    output AXIS_TDATA,
    output AXIS_TVALID,
    input  AXIS_TREADY
  );

  modport slave (
    input  AXIS_TDATA,
    input  AXIS_TVALID,
    output AXIS_TREADY
  );

endinterface

// File: rtl/matmul_compute.sv
// ---------------------------------------------------------------------------
// matmul_compute
// Computes C = A * B (A is MxK, B is KxN) with a single signed MAC. It reads
// both operand memories through 1-cycle-latency read ports and streams C out
// row-major over AXI-Stream.
//
// Ports:
//   clk               single clock, all logic on posedge
//   reset             synchronous, active-low
//   matrices_loaded   A/B memories and K are valid
//   K                 inner dimension, latched when a computation starts
//   compute_finished  one-cycle pulse after the last C element is accepted
//   A_read_addr       A address, A[m][k] at m*K+k
//   A_data            mem_A[A_read_addr] of the previous cycle (signed)
//   B_read_addr       B address, B[k][n] at k*N+n
//   B_data            mem_B[B_read_addr] of the previous cycle (signed)
//   axis              AXI-Stream master carrying the C elements
// ---------------------------------------------------------------------------
module matmul_compute #(
  parameter  int INW         = 12,
  parameter  int OUTW        = 28,
  parameter  int M           = 7,
  parameter  int N           = 9,
  parameter  int MAXK        = 8,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int A_ADDR_BITS = $clog2(M * MAXK),
  localparam int B_ADDR_BITS = $clog2(MAXK * N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    matrices_loaded,
  input  logic [K_BITS-1:0]       K,
  output logic                    compute_finished,
  output logic [A_ADDR_BITS-1:0]  A_read_addr,
  input  logic signed [INW-1:0]   A_data,
  output logic [B_ADDR_BITS-1:0]  B_read_addr,
  input  logic signed [INW-1:0]   B_data,
  matmul_compute_if.master        axis
);

  localparam int M_BITS = (M > 1) ? $clog2(M) : 1;
  localparam int N_BITS = (N > 1) ? $clog2(N) : 1;
  localparam logic [M_BITS-1:0] M_LAST = M_BITS'(M - 1);
  localparam logic [N_BITS-1:0] N_LAST = N_BITS'(N - 1);
  localparam logic [K_BITS-1:0] K_ONE  = K_BITS'(1);

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    OUT,
    DONE,
    WAIT_CLR
  } state_t;

  state_t                 state;
  logic [K_BITS-1:0]      kr;
  logic [K_BITS-1:0]      k;
  logic [M_BITS-1:0]      m;
  logic [N_BITS-1:0]      n;
  logic signed [OUTW-1:0] acc;
  logic                   mac_d;

  logic signed [2*INW-1:0] product;
  logic signed [OUTW-1:0]  acc_next;
  logic [31:0]             a_lin;
  logic [31:0]             b_lin;

  // Read data arrives one cycle after the address, so the accumulate is
  // gated by whether the previous cycle was a MAC cycle. The full-width
  // product is sign-extended by the size cast and wraps modulo 2^OUTW.
  always_comb begin
    product  = A_data * B_data;
    acc_next = acc;
    if (mac_d) begin
      acc_next = acc + OUTW'(product);
    end
  end

  // Addresses are formed straight from the counters so they are valid in
  // the MAC cycle itself; outside MAC they rest at zero.
  always_comb begin
    a_lin       = 32'(m) * 32'(kr) + 32'(k);
    b_lin       = 32'(k) * 32'(N) + 32'(n);
    A_read_addr = '0;
    B_read_addr = '0;
    if (state == MAC) begin
      A_read_addr = A_ADDR_BITS'(a_lin);
      B_read_addr = B_ADDR_BITS'(b_lin);
    end
  end

  // Control FSM with registered outputs. With Kr=0 the machine still passes
  // through DRAIN (which then accumulates nothing) so TVALID gets its one
  // idle cycle between elements and every element costs Kr+2 cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      kr               <= '0;
      k                <= '0;
      m                <= '0;
      n                <= '0;
      acc              <= '0;
      mac_d            <= 1'b0;
      compute_finished <= 1'b0;
      axis.AXIS_TVALID <= 1'b0;
      axis.AXIS_TDATA  <= '0;
    end else begin
      mac_d            <= (state == MAC);
      compute_finished <= 1'b0;
      acc              <= acc_next;

      case (state)
        IDLE: begin
          if (matrices_loaded) begin
            kr    <= K;
            k     <= '0;
            m     <= '0;
            n     <= '0;
            acc   <= '0;
            state <= (K != '0) ? MAC : DRAIN;
          end
        end

        MAC: begin
          k <= k + K_ONE;
          if (k == kr - K_ONE) begin
            state <= DRAIN;
          end
        end

        DRAIN: begin
          axis.AXIS_TVALID <= 1'b1;
          axis.AXIS_TDATA  <= acc_next;
          state            <= OUT;
        end

        OUT: begin
          if (axis.AXIS_TREADY) begin
            axis.AXIS_TVALID <= 1'b0;
            if (m == M_LAST && n == N_LAST) begin
              compute_finished <= 1'b1;
              state            <= DONE;
            end else begin
              if (n == N_LAST) begin
                n <= '0;
                m <= m + 1'b1;
              end else begin
                n <= n + 1'b1;
              end
              k     <= '0;
              acc   <= '0;
              state <= (kr != '0) ? MAC : DRAIN;
            end
          end
        end

        DONE: begin
          state <= WAIT_CLR;
        end

        WAIT_CLR: begin
          if (!matrices_loaded) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
